axi_slave_read_data: RTL

Downstream stage of the AXI3 slave read-address block. It consumes read requests that the address stage has already accepted and range/burst-checked, and buffers them in a small in-order FIFO. For each request it generates per-beat addresses (FIXED/INCR/WRAP), reads a synchronous slave memory port, and drives the AXI read data channel (rid/rdata/rresp/rlast/rvalid) under rready backpressure.

---
 rtl/axi_slave_read_data.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_read_data.sv
// Request FIFO plus beat generator for the AXI3 read data channel.
// Latency: accept -> first rvalid 3 cycles; 3 cycles per beat with rready high.
// Backpressure: rready low freezes the R outputs; req_ready drops when 4 requests wait.

module axi_slave_read_data_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
    // count never exceeds DEPTH, so its MSB alone marks full
    assign full    = count[AW];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module axi_slave_read_data #(
    parameter int TXID       = 4,
    parameter int ADDR       = 32,
    parameter int DATA       = 32,
    parameter int BUFF_RANGE = 2
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [TXID-1:0] req_id,
    input  logic [ADDR-1:0] req_addr,
    input  logic [3:0]      req_len,
    input  logic [2:0]      req_size,
    input  logic [1:0]      req_burst,
    input  logic            req_err,
    output logic            mem_ren,
    output logic [ADDR-1:0] mem_addr,
    input  logic [DATA-1:0] mem_rdata,
    output logic [TXID-1:0] rid,
    output logic [DATA-1:0] rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);
    localparam int STRB = DATA / 8;
    localparam int LSB  = $clog2(STRB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    typedef struct packed {
        logic [TXID-1:0] id;
        logic [ADDR-1:0] addr;
        logic [3:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic            err;
    } req_t;

    req_t            in_req;
    req_t            head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;

    logic [1:0]      state;
    logic [TXID-1:0] b_id;
    logic [ADDR-1:0] cur_addr;
    logic [3:0]      b_len;
    logic [2:0]      b_size;
    logic [1:0]      b_burst;
    logic            b_err;
    logic [3:0]      beat;
    logic [ADDR-1:0] wrap_lower;
    logic [ADDR-1:0] wrap_bound;

    logic [ADDR-1:0] head_total;
    logic [ADDR-1:0] head_lower;
    logic [ADDR-1:0] step;
    logic [ADDR-1:0] incr_nxt;
    logic [ADDR-1:0] next_addr;

    // Reserved burst type and oversize beats are folded into the error flag at entry
    always_comb begin
        in_req       = '0;
        in_req.id    = req_id;
        in_req.addr  = req_addr;
        in_req.len   = req_len;
        in_req.size  = req_size;
        in_req.burst = req_burst;
        in_req.err   = req_err || (req_burst == 2'b11) || (int'(req_size) > LSB);
    end

    assign req_ready = !fifo_full && !areset;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && !fifo_empty;

    axi_slave_read_data_fifo #(
        .W  ($bits(req_t)),
        .AW (BUFF_RANGE)
    ) u_fifo (
        .clk      (aclk),
        .rst      (areset),
        .push     (push),
        .push_dat (in_req),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign head_total = (ADDR'(head.len) + ADDR'(1)) << head.size;
    assign head_lower = head.addr & ~(head_total - ADDR'(1));

    assign step     = ADDR'(1) << b_size;
    assign incr_nxt = cur_addr + step;

    always_comb begin
        next_addr = cur_addr;
        case (b_burst)
            2'b01:   next_addr = (cur_addr & ~(step - ADDR'(1))) + step;
            2'b10:   next_addr = (incr_nxt == wrap_bound) ? wrap_lower : incr_nxt;
            default: next_addr = cur_addr;
        endcase
    end

    assign mem_ren  = (state == RD) && !b_err;
    assign mem_addr = {cur_addr[ADDR-1:LSB], {LSB{1'b0}}};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            b_id       <= '0;
            cur_addr   <= '0;
            b_len      <= '0;
            b_size     <= '0;
            b_burst    <= '0;
            b_err      <= 1'b0;
            beat       <= '0;
            wrap_lower <= '0;
            wrap_bound <= '0;
            rid        <= '0;
            rdata      <= '0;
            rresp      <= 2'b00;
            rlast      <= 1'b0;
            rvalid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        b_id       <= head.id;
                        cur_addr   <= head.addr;
                        b_len      <= head.len;
                        b_size     <= head.size;
                        b_burst    <= head.burst;
                        b_err      <= head.err;
                        beat       <= '0;
                        wrap_lower <= head_lower;
                        wrap_bound <= head_lower + head_total;
                        state      <= RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    rdata  <= b_err ? '0 : mem_rdata;
                    rresp  <= b_err ? 2'b10 : 2'b00;
                    rid    <= b_id;
                    rlast  <= (beat == b_len);
                    rvalid <= 1'b1;
                    state  <= RESP;
                end
                default: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (beat == b_len) begin
                            state <= IDLE;
                        end else begin
                            cur_addr <= next_addr;
                            beat     <= beat + 1'b1;
                            state    <= RD;
                        end
                    end
                end
            endcase
        end
    end
endmodule
